// File: rtl/imhotep_ram.sv
// Byte-addressable little-endian data RAM for the imhotep load/store path.
// Latency: writes land on the clock edge; reads are registered, data_o valid one edge later.
// Backpressure: none; every edge outside reset performs exactly one access selected by w_rn_i.
module imhotep_ram #(
  parameter int XLEN      = 32,
  parameter int RAM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 w_rn_i,
  input  logic [1:0]           width_i,
  input  logic [XLEN-1:0]      data_i,
  input  logic [RAM_WIDTH-1:0] addr_i,
  output logic [XLEN-1:0]      data_o
);

  localparam int NBYTES = XLEN / 8;
  localparam int DEPTH  = 1 << RAM_WIDTH;

  logic [7:0]           mem_q [DEPTH];
  logic [XLEN-1:0]      data_q;
  logic [XLEN-1:0]      data_d;
  logic [NBYTES-1:0]    lane_en;
  logic [RAM_WIDTH-1:0] lane_addr [NBYTES];

  // Lane k covers byte address A+k; the width code enables a low-order prefix of lanes.
  always_comb begin
    lane_en = '0;
    case (width_i)
      2'b00:   lane_en = NBYTES'(1);
      2'b01:   lane_en = NBYTES'(3);
      2'b10:   lane_en = '1;
      default: lane_en = '0;
    endcase
  end

  // Address arithmetic is truncated to RAM_WIDTH bits, so accesses wrap past the top.
  always_comb begin
    for (int k = 0; k < NBYTES; k++) begin
      lane_addr[k] = addr_i + RAM_WIDTH'(k);
    end
  end

  // Storage is deliberately not reset; the reset_n gate keeps stray inputs out during reset.
  always_ff @(posedge clk) begin
    if (reset_n && w_rn_i) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (lane_en[k]) begin
          mem_q[lane_addr[k]] <= data_i[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    data_d = data_q;
    if (!w_rn_i) begin
      for (int k = 0; k < NBYTES; k++) begin
        data_d[8*k +: 8] = lane_en[k] ? mem_q[lane_addr[k]] : 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_imhotep_ram.sv
// Self-checking bench for imhotep_ram: byte-map reference model plus directed literal checks.
module tb_imhotep_ram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        w_rn;
  logic [1:0]  width;
  logic [31:0] din;
  logic [15:0] addr;
  logic [31:0] dout;

  int n_tests = 0;
  int n_fail  = 0;

  bit   [7:0]  model_mem [int];
  logic [31:0] exp_q;
  bit          exp_known = 1'b0;
  logic [31:0] e;
  bit          known;

  always #5 clk = ~clk;

  imhotep_ram #(.XLEN(32), .RAM_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .w_rn_i  (w_rn),
    .width_i (width),
    .data_i  (din),
    .addr_i  (addr),
    .data_o  (dout)
  );

  function automatic int nbytes(input logic [1:0] w);
    case (w)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  // Reference model: a sparse byte map; a read is only judged when every byte it covers is known.
  always @(posedge clk) begin
    if (!reset_n) begin
      exp_q     = 32'h0;
      exp_known = 1'b1;
    end else if (w_rn) begin
      for (int k = 0; k < nbytes(width); k++) begin
        model_mem[(int'(addr) + k) % 65536] = din[8*k +: 8];
      end
    end else begin
      e     = 32'h0;
      known = 1'b1;
      for (int k = 0; k < nbytes(width); k++) begin
        if (model_mem.exists((int'(addr) + k) % 65536)) begin
          e[8*k +: 8] = model_mem[(int'(addr) + k) % 65536];
        end else begin
          known = 1'b0;
        end
      end
      exp_q     = e;
      exp_known = known;
    end
    #1;
    if (exp_known) begin
      n_tests++;
      if (dout !== exp_q) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t addr=%h got %h expected %h", $time, addr, dout, exp_q);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] expv);
    n_tests++;
    if (dout !== expv) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, dout, expv);
    end
  endtask

  task automatic acc(input logic w, input logic [1:0] wd, input logic [15:0] a, input logic [31:0] d);
    w_rn  = w;
    width = wd;
    addr  = a;
    din   = d;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    w_rn    = 1'bx;
    width   = 2'bxx;
    din     = 'x;
    addr    = 'x;
    @(negedge clk);
    @(negedge clk);
    chk("reset_value", 32'h0);

    w_rn    = 1'b1;
    width   = 2'b11;
    addr    = 16'h0;
    din     = 32'h0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_hold", 32'h0);

    // Byte access; neighbours pre-filled so "unwritten" is observable.
    acc(1'b1, 2'b10, 16'h1000, 32'h5A5A5A5A);
    acc(1'b1, 2'b00, 16'h1000, 32'hFFFFFFFF);
    acc(1'b0, 2'b00, 16'h1000, 32'h0);
    chk("byte_read", 32'h000000FF);
    acc(1'b0, 2'b10, 16'h1000, 32'h0);
    chk("byte_neighbours", 32'h5A5A5AFF);

    // Halfword access.
    acc(1'b1, 2'b10, 16'h2000, 32'h12345678);
    acc(1'b1, 2'b01, 16'h2000, 32'hFFFFFFFF);
    acc(1'b0, 2'b01, 16'h2000, 32'h0);
    chk("half_read", 32'h0000FFFF);
    acc(1'b0, 2'b10, 16'h2000, 32'h0);
    chk("half_neighbours", 32'h1234FFFF);

    // Word access and partial overwrite.
    acc(1'b1, 2'b10, 16'h3000, 32'hFFFFFFFF);
    acc(1'b0, 2'b10, 16'h3000, 32'h0);
    chk("word_read", 32'hFFFFFFFF);
    acc(1'b1, 2'b01, 16'h3000, 32'h0);
    chk("write_holds_dout", 32'hFFFFFFFF);
    acc(1'b0, 2'b10, 16'h3000, 32'h0);
    chk("partial_overwrite", 32'hFFFF0000);

    // Little-endian, misaligned.
    acc(1'b1, 2'b10, 16'h4001, 32'h11223344);
    acc(1'b0, 2'b00, 16'h4001, 32'h0);
    chk("le_byte0", 32'h44);
    acc(1'b0, 2'b00, 16'h4002, 32'h0);
    chk("le_byte1", 32'h33);
    acc(1'b0, 2'b00, 16'h4003, 32'h0);
    chk("le_byte2", 32'h22);
    acc(1'b0, 2'b00, 16'h4004, 32'h0);
    chk("le_byte3", 32'h11);
    acc(1'b0, 2'b01, 16'h4002, 32'h0);
    chk("misaligned_half", 32'h00002233);

    // Wrap-around at the top of memory.
    acc(1'b1, 2'b10, 16'hFFFE, 32'hAABBCCDD);
    acc(1'b0, 2'b00, 16'h0000, 32'h0);
    chk("wrap_byte0", 32'h000000BB);
    acc(1'b0, 2'b00, 16'h0001, 32'h0);
    chk("wrap_byte1", 32'h000000AA);
    acc(1'b0, 2'b10, 16'hFFFE, 32'h0);
    chk("wrap_word", 32'hAABBCCDD);

    // Illegal width: write is a no-op, read returns zero.
    acc(1'b1, 2'b11, 16'h3000, 32'h0);
    chk("illegal_write_hold", 32'hAABBCCDD);
    acc(1'b0, 2'b10, 16'h3000, 32'h0);
    chk("illegal_write_nop", 32'hFFFF0000);
    acc(1'b0, 2'b11, 16'h3000, 32'h0);
    chk("illegal_read_zero", 32'h0);

    // Asynchronous reset mid-cycle, and writes suppressed while it is held.
    acc(1'b0, 2'b10, 16'h4001, 32'h0);
    chk("pre_reset_read", 32'h11223344);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 32'h0);
    w_rn  = 1'b1;
    width = 2'b10;
    addr  = 16'h4001;
    din   = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    chk("reset_held", 32'h0);
    reset_n = 1'b1;
    acc(1'b0, 2'b10, 16'h4001, 32'h0);
    chk("no_write_in_reset", 32'h11223344);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
